// File: rtl/wb_arbiter_pkg.sv
// Shared definitions for the writeback arbiter: default widths, request record
// and the saturating statistics increment.
package wb_arbiter_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned STAT_W     = 16;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
  } wb_req_t;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/wb_arbiter_rr_picker.sv
// Cyclic priority search: first set bit of valid at or above start, wrapping.
module rr_picker #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     valid,
  input  logic [IDX_W-1:0] start,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    int unsigned cand;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = 0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = (32'(start) + k) % N;
      if (!any && valid[cand]) begin
        grant[cand] = 1'b1;
        idx         = IDX_W'(cand);
        any         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin writeback arbiter: grants one requester per cycle into a single
// registered register-file write port, with per-requester accept counters.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NREQ   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*ADDR_W-1:0]    req_addr,
  input  logic [NREQ*DATA_W-1:0]    req_data,
  input  logic                      flush,
  output logic                      wr_en,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [DATA_W-1:0]         wr_data,
  output logic [$clog2(NREQ)-1:0]   grant_idx,
  input  logic [$clog2(NREQ)-1:0]   stat_sel,
  output logic [15:0]               stat_cnt
);

  localparam int IDX_W = $clog2(NREQ);

  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  pick_idx;
  logic [IDX_W-1:0]  next_ptr;
  logic [NREQ-1:0]   pick_grant;
  logic              pick_any;
  logic              xfer;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic [STAT_W-1:0] stat [NREQ];

  rr_picker #(
    .N     (NREQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .valid (req_valid),
    .start (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Grants are suppressed while in reset or flushing, so nothing is accepted then.
  always_comb begin
    req_ready = (rst || flush) ? '0 : pick_grant;
    xfer      = pick_any && !rst && !flush;
    sel_addr  = req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
    sel_data  = req_data[int'(pick_idx)*DATA_W +: DATA_W];
    next_ptr  = (int'(pick_idx) == NREQ-1) ? '0 : pick_idx + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      grant_idx <= '0;
      rr_ptr    <= '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
        stat[i] <= '0;
      end
    end else begin
      // Address 0 is accepted and counted but never written.
      wr_en <= xfer && (sel_addr != '0);
      if (xfer) begin
        wr_addr        <= sel_addr;
        wr_data        <= sel_data;
        grant_idx      <= pick_idx;
        rr_ptr         <= next_ptr;
        stat[pick_idx] <= sat_inc(stat[pick_idx]);
      end else if (flush) begin
        rr_ptr <= '0;
      end
    end
  end

  always_comb begin
    stat_cnt = '0;
    if (int'(stat_sel) < NREQ) begin
      stat_cnt = stat[stat_sel];
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: stimulus queues expected writes, a negedge
// monitor pops and compares them, and a hold checker watches waiting requesters.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [9:0]  req_addr;
  logic [63:0] req_data;
  logic        flush;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [0:0]  grant_idx;
  logic [0:0]  stat_sel;
  logic [15:0] stat_cnt;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    wb_req_t    req;
    logic [0:0] idx;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] shadow [32];

  wb_arbiter #(
    .DATA_W (32),
    .ADDR_W (5),
    .NREQ   (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .flush     (flush),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .grant_idx (grant_idx),
    .stat_sel  (stat_sel),
    .stat_cnt  (stat_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_stat(input logic s, input logic [15:0] exp, input string name);
    stat_sel = s;
    #1;
    chk(name, {16'h0, stat_cnt}, {16'h0, exp});
  endtask

  // Drive one cycle of requests, check the combinational grant, queue the write.
  task automatic step(input logic [1:0] v, input logic [4:0] a0, input logic [4:0] a1,
                      input logic [31:0] d0, input logic [31:0] d1, input logic fl,
                      input logic [1:0] exp_rdy, input logic push, input string tag);
    exp_t e;
    req_valid = v;
    req_addr  = {a1, a0};
    req_data  = {d1, d0};
    flush     = fl;
    #1;
    chk({"ready_", tag}, {30'h0, req_ready}, {30'h0, exp_rdy});
    if (push && exp_rdy != 2'b00) begin
      e.idx      = exp_rdy[1];
      e.req.addr = exp_rdy[1] ? a1 : a0;
      e.req.data = exp_rdy[1] ? d1 : d0;
      if (e.req.addr != 5'd0) exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got wr_en=1 addr=0x%0h data=0x%0h required no write",
                 wr_addr, wr_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("mon_wr_addr", {27'h0, wr_addr}, {27'h0, e.req.addr});
        chk("mon_wr_data", wr_data, e.req.data);
        chk("mon_grant_idx", {31'h0, grant_idx}, {31'h0, e.idx});
      end
      shadow[wr_addr] = wr_data;
    end
  end

  logic [1:0]  pw = '0;
  logic [4:0]  pa [2];
  logic [31:0] pd [2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (pw[i]) begin
        checks++;
        if (req_valid[i] !== 1'b1 || req_addr[i*5 +: 5] !== pa[i] || req_data[i*32 +: 32] !== pd[i]) begin
          failures++;
          $display("FAIL hold_req%0d: got valid=%0b addr=0x%0h data=0x%0h required valid=1 addr=0x%0h data=0x%0h",
                   i, req_valid[i], req_addr[i*5 +: 5], req_data[i*32 +: 32], pa[i], pd[i]);
        end
      end
      pw[i] <= req_valid[i] && !req_ready[i] && !rst;
      pa[i] <= req_addr[i*5 +: 5];
      pd[i] <= req_data[i*32 +: 32];
    end
  end

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    flush     = 1'b0;
    stat_sel  = '0;
    for (int i = 0; i < 32; i++) shadow[i] = '0;

    @(posedge clk);
    #1;
    req_valid = 2'b11;
    #1;
    chk("rst_ready", {30'h0, req_ready}, 32'h0);
    req_valid = 2'b00;
    chk("rst_wr_en", {31'h0, wr_en}, 32'h0);
    chk("rst_wr_addr", {27'h0, wr_addr}, 32'h0);
    chk("rst_wr_data", wr_data, 32'h0);
    chk("rst_grant_idx", {31'h0, grant_idx}, 32'h0);
    chk_stat(1'b0, 16'd0, "rst_stat0");
    chk_stat(1'b1, 16'd0, "rst_stat1");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single write, visible one cycle after acceptance.
    step(2'b01, 5'd3, 5'd0, 32'hDEADBEEF, 32'h0, 1'b0, 2'b01, 1'b1, "t1");
    chk("t1_wr_en", {31'h0, wr_en}, 32'h1);
    chk("t1_wr_addr", {27'h0, wr_addr}, 32'd3);
    chk("t1_wr_data", wr_data, 32'hDEADBEEF);

    // Address 0 from req1 (rr_ptr=1): accepted, counted, not written.
    step(2'b10, 5'd0, 5'd0, 32'h0, 32'h55, 1'b0, 2'b10, 1'b1, "t3");
    chk("t3_wr_en", {31'h0, wr_en}, 32'h0);
    chk("t3_grant_idx", {31'h0, grant_idx}, 32'h1);
    chk_stat(1'b1, 16'd1, "t3_stat1");

    // Both requesting from rr_ptr=0: alternating grants.
    step(2'b11, 5'd1, 5'd2, 32'h100, 32'h200, 1'b0, 2'b01, 1'b1, "t2a");
    step(2'b11, 5'd4, 5'd2, 32'h400, 32'h200, 1'b0, 2'b10, 1'b1, "t2b");
    step(2'b11, 5'd4, 5'd5, 32'h400, 32'h500, 1'b0, 2'b01, 1'b1, "t2c");
    step(2'b11, 5'd6, 5'd5, 32'h600, 32'h500, 1'b0, 2'b10, 1'b1, "t2d");
    step(2'b01, 5'd6, 5'd0, 32'h600, 32'h0,   1'b0, 2'b01, 1'b1, "t2e");

    // Flush with rr_ptr=1 and a write pending; then same-address serialisation.
    step(2'b11, 5'd7, 5'd7, 32'h1, 32'h2, 1'b1, 2'b00, 1'b1, "t4flush");
    step(2'b11, 5'd7, 5'd7, 32'h1, 32'h2, 1'b0, 2'b01, 1'b1, "t4g0");
    step(2'b10, 5'd7, 5'd7, 32'h1, 32'h2, 1'b0, 2'b10, 1'b1, "t4g1");
    step(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 2'b00, 1'b0, "t4idle");
    chk("t4_r7_final", shadow[7], 32'h2);
    chk_stat(1'b0, 16'd5, "t4_stat0");
    chk_stat(1'b1, 16'd4, "t4_stat1");

    // Reset right after an accepted transfer discards its write.
    step(2'b01, 5'd9, 5'd0, 32'h99, 32'h0, 1'b0, 2'b01, 1'b0, "t5");
    rst       = 1'b1;
    req_valid = 2'b00;
    #1;
    chk("t5_wr_en", {31'h0, wr_en}, 32'h0);
    chk("t5_wr_addr", {27'h0, wr_addr}, 32'h0);
    chk("t5_grant_idx", {31'h0, grant_idx}, 32'h0);
    chk_stat(1'b0, 16'd0, "t5_stat0");
    chk_stat(1'b1, 16'd0, "t5_stat1");
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("t5_post_wr_en", {31'h0, wr_en}, 32'h0);
    end

    // Pointer cleared by reset: req0 wins first.
    step(2'b11, 5'd10, 5'd11, 32'hA, 32'hB, 1'b0, 2'b01, 1'b1, "t6a");
    step(2'b10, 5'd10, 5'd11, 32'hA, 32'hB, 1'b0, 2'b10, 1'b1, "t6b");
    step(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 2'b00, 1'b0, "t6idle");
    step(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 2'b00, 1'b0, "t6idle2");
    chk("queue_drained", exp_q.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
